// File: rtl/led_writer.sv
// rtl/led_writer.sv - Avalon-MM LED driver: hold/blink/rotate a pattern off an internal tick counter
// Optional LED_PWM_EN: CTRL[15:8] duty gates led against a free-running 8-bit pwm_cnt.
module led_writer #(
  parameter int               LED_W      = 10,
  parameter int               CNT_W      = 24,
  parameter logic [CNT_W-1:0] PERIOD_RST = 24'd12_499_999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led
);

  logic [LED_W-1:0] data_q;
  logic             blink_en;
  logic             rotate_en;
  logic             rotate_dir;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt;
  logic             phase;
  logic             wr_en;
  logic             rd_en;
  logic             restart;
  logic             wrap;
  logic             tick;
  logic [7:0]       ctrl_hi;
  logic [LED_W-1:0] gate;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en        = chipselect && write;
  assign rd_en        = chipselect && read;
  assign unused_wdata = ^writedata;

  // A PERIOD or SYNC write restarts the timebase and suppresses that cycle's tick.
  assign restart = wr_en && ((address == 2'd2) || (address == 2'd3));
  assign wrap    = (cnt == period_q);
  assign tick    = wrap && !restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= '0;
      blink_en   <= 1'b0;
      rotate_en  <= 1'b0;
      rotate_dir <= 1'b0;
      period_q   <= PERIOD_RST;
    end else begin
      // Bus write to DATA beats a coincident rotate tick.
      if (wr_en && (address == 2'd0)) begin
        data_q <= writedata[LED_W-1:0];
      end else if (tick && rotate_en) begin
        data_q <= rotate_dir ? {data_q[0], data_q[LED_W-1:1]}
                             : {data_q[LED_W-2:0], data_q[LED_W-1]};
      end
      if (wr_en && (address == 2'd1)) begin
        {rotate_dir, rotate_en, blink_en} <= writedata[2:0];
      end
      if (wr_en && (address == 2'd2)) begin
        period_q <= writedata[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 1'b1;
    end else if ((wr_en && (address == 2'd3)) || !blink_en) begin
      phase <= 1'b1;
    end else if (tick) begin
      phase <= ~phase;
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty    <= 8'hFF;
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_en && (address == 2'd1)) begin
        duty <= writedata[15:8];
      end
    end
  end

  assign gate    = {LED_W{pwm_cnt < duty}};
  assign ctrl_hi = duty;
`else
  assign gate    = '1;
  assign ctrl_hi = 8'h00;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      2'd0:    rd_mux = {{(32-LED_W){1'b0}}, data_q};
      2'd1:    rd_mux = {16'h0, ctrl_hi, 5'b0, rotate_dir, rotate_en, blink_en};
      2'd2:    rd_mux = {{(32-CNT_W){1'b0}}, period_q};
      default: rd_mux = {31'h0, phase};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0;
      led      <= '0;
    end else begin
      if (rd_en) begin
        readdata <= rd_mux;
      end
      led <= (phase ? data_q : '0) & gate;
    end
  end

endmodule

// File: tb/tb_led_writer.sv
// tb/tb_led_writer.sv - scoreboard bench for led_writer (hold, blink, rotate, sync, reset, optional PWM)
`timescale 1ns/1ps
module tb_led_writer;

  localparam int               LED_W      = 10;
  localparam int               CNT_W      = 24;
  localparam logic [CNT_W-1:0] PERIOD_RST = 24'd12_499_999;
`ifdef LED_PWM_EN
  localparam logic [31:0]      DUTY_BITS  = 32'h0000_FF00;
`else
  localparam logic [31:0]      DUTY_BITS  = 32'h0000_0000;
`endif
  localparam logic [31:0]      CTRL_HI    = 32'h0000_FF00;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             read = 1'b0;
  logic             write = 1'b0;
  logic [31:0]      writedata = 32'h0;
  logic [31:0]      readdata;
  logic [LED_W-1:0] led;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_led[$];
  logic [31:0] exp_rd[$];

  led_writer #(.LED_W(LED_W), .CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata), .led(led)
  );

  always #5 clk = ~clk;

`ifdef LED_PWM_EN
  logic [7:0] pwm_model;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_model <= 8'h00;
    else          pwm_model <= pwm_model + 8'd1;
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    exp_rd.push_back(exp);
    address = a; chipselect = 1'b1; read = 1'b1;
    step();
    chipselect = 1'b0; read = 1'b0;
    check(tag, readdata, exp_rd.pop_front());
  endtask

  task automatic chk_led(input string tag);
    logic [31:0] e;
    e = exp_led.pop_front();
`ifdef LED_PWM_EN
    // with duty 255 the led is dark while the previous pwm count was 255
    if (8'(pwm_model - 8'd1) == 8'hFF) e = 32'h0;
`endif
    check(tag, 32'(led), e);
  endtask

  function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

  initial begin
    logic [LED_W-1:0] v;

    // reset state
    repeat (3) step();
    check("rst_led", 32'(led), 32'h0);
    check("rst_rd", readdata, 32'h0);
    reset_n = 1'b1;
    rd("rst_period", 2'd2, 32'(PERIOD_RST));
    rd("rst_ctrl", 2'd1, DUTY_BITS);
    rd("rst_phase", 2'd3, 32'h1);
    check("rst_led2", 32'(led), 32'h0);

    // static hold
    wr(2'd0, 32'h2AA);
    check("hold_lat", 32'(led), 32'h0);
    wr(2'd1, CTRL_HI);
    for (int k = 0; k < 8; k++) exp_led.push_back(32'h2AA);
    chk_led("hold");
    for (int k = 0; k < 7; k++) begin step(); chk_led("hold"); end
    rd("ctrl_rb", 2'd1, DUTY_BITS);

    // simultaneous read/write returns the old value; readdata holds; chipselect qualifies
    address = 2'd0; writedata = 32'h111; chipselect = 1'b1; read = 1'b1; write = 1'b1;
    step();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    check("rw_old", readdata, 32'h2AA);
    step(); step();
    check("rd_hold", readdata, 32'h2AA);
    rd("rw_new", 2'd0, 32'h111);
    address = 2'd2; read = 1'b1;
    step();
    read = 1'b0;
    check("no_cs", readdata, 32'h111);

    // blink with PERIOD=3, aligned by a SYNC write; phase readback follows
    wr(2'd2, 32'd3);
    wr(2'd1, CTRL_HI | 32'h1);
    wr(2'd0, 32'h155);
    wr(2'd3, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      exp_led.push_back((((k - 1) / 4) % 2 == 0) ? 32'h155 : 32'h0);
      exp_rd.push_back((((k - 1) / 4) % 2 == 0) ? 32'h1 : 32'h0);
    end
    address = 2'd3; chipselect = 1'b1; read = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk_led("blink");
      check("phase_rd", readdata, exp_rd.pop_front());
    end
    chipselect = 1'b0; read = 1'b0;

    // rotate left every cycle, wrapping bit 9 -> bit 0
    wr(2'd2, 32'd0);
    wr(2'd1, CTRL_HI | 32'h2);
    wr(2'd0, 32'h200);
    v = 10'h200;
    for (int k = 1; k <= 12; k++) begin
      exp_led.push_back(32'(v));
      v = rotl(v);
    end
    for (int k = 1; k <= 12; k++) begin step(); chk_led("rot_left"); end

    // rotate right, then DATA writes landing on tick cycles win
    wr(2'd1, CTRL_HI | 32'h6);
    wr(2'd0, 32'h001);
    exp_led.push_back(32'h001); exp_led.push_back(32'h200); exp_led.push_back(32'h100);
    for (int k = 0; k < 3; k++) begin step(); chk_led("rot_right"); end
    wr(2'd0, 32'h201);
    exp_led.push_back(32'h201); exp_led.push_back(32'h300); exp_led.push_back(32'h180);
    for (int k = 0; k < 3; k++) begin step(); chk_led("wr_wins"); end
    wr(2'd0, 32'h3FF);
    exp_led.push_back(32'h3FF); exp_led.push_back(32'h3FF);
    for (int k = 0; k < 2; k++) begin step(); chk_led("wr_3ff"); end

    // mid-count SYNC restarts the timebase: next tick PERIOD+1 cycles later
    wr(2'd2, 32'd5);
    wr(2'd1, CTRL_HI | 32'h1);
    wr(2'd0, 32'h0F0);
    wr(2'd3, 32'h0);
    repeat (3) step();
    wr(2'd3, 32'h0);
    for (int k = 1; k <= 14; k++)
      exp_led.push_back((((k - 1) / 6) % 2 == 0) ? 32'h0F0 : 32'h0);
    for (int k = 1; k <= 14; k++) begin step(); chk_led("sync"); end
    rd("data_rb", 2'd0, 32'h0F0);
    check("pre_rst_led", 32'(led), 32'h0F0);

    // asynchronous reset mid-blink
    #2 reset_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h0);
    check("arst_rd", readdata, 32'h0);
    step();
    reset_n = 1'b1;
    rd("arst_period", 2'd2, 32'(PERIOD_RST));
    rd("arst_ctrl", 2'd1, DUTY_BITS);
    rd("arst_data", 2'd0, 32'h0);
    rd("arst_phase", 2'd3, 32'h1);
    check("arst_led2", 32'(led), 32'h0);

`ifdef LED_PWM_EN
    begin
      int on_cnt;
      wr(2'd1, 32'h0000_4000);
      wr(2'd0, 32'h001);
      step(); step();
      exp_rd.push_back(32'd64);
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin step(); if (led[0]) on_cnt++; end
      check("pwm_64", 32'(on_cnt), exp_rd.pop_front());
      wr(2'd1, 32'h0);
      step(); step();
      exp_rd.push_back(32'd0);
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin step(); if (led[0]) on_cnt++; end
      check("pwm_0", 32'(on_cnt), exp_rd.pop_front());
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_writer.md
Name: led_writer

Overview:
- Avalon-MM write/read slave that drives the board LEDs. It is the output-side counterpart of the switch reader.
- Software writes a pattern, mode and period. The block then holds, blinks or rotates the pattern on its own using an internal tick counter.
- It sits on the same peripheral bus as the switch reader. `led` goes straight to the pins.

Parameters:
- LED_W, 10, number of LED outputs and width of the DATA register.
- CNT_W, 24, width of the tick counter and the PERIOD register.
- PERIOD_RST, 24'd12_499_999, PERIOD value at reset (0.25 s tick at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select; qualifies read and write.
- read  input  1  read strobe.
- write  input  1  write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- led  output  LED_W  LED drive, registered.

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `reset_n` is asynchronous and active-low.
  - All state returns to reset values immediately on assertion, including mid-operation.
- Register map:
  - 0 DATA: rw, bits[LED_W-1:0].
  - 1 CTRL: rw. bit0 blink_en, bit1 rotate_en, bit2 rotate_dir (0 = left, 1 = right).
  - 2 PERIOD: rw, bits[CNT_W-1:0].
  - 3 SYNC: read returns {31'b0, phase}; any write restarts the timebase.
  - Unused bits read 0 and are ignored on write.
- Write:
  - Happens when chipselect && write at a rising clk edge.
  - The register updates on that edge.
  - The effect on `led` is visible one cycle later.
- Read:
  - When chipselect && read, readdata is loaded on the edge; 1-cycle latency.
  - Otherwise readdata holds its last value.
  - Read and write to the same address in the same cycle return the old value.
- Reset values:
  - DATA = 0, CTRL = 0, PERIOD = PERIOD_RST.
  - cnt = 0, phase = 1, readdata = 0, led = 0.
- Tick counter:
  - cnt counts 0..PERIOD.
  - When cnt == PERIOD: a one-cycle tick pulse is generated and cnt wraps to 0.
  - This gives a period of PERIOD+1 cycles. PERIOD = 0 ticks every cycle.
  - A write to PERIOD or SYNC forces cnt = 0, and that cycle does not tick.
  - A write to SYNC also forces phase = 1.
- Blink:
  - phase toggles on each tick when blink_en = 1.
  - When blink_en = 0, phase is held at 1.
- Rotate (rotate_en = 1), on each tick:
  - Left: DATA <= {DATA[LED_W-2:0], DATA[LED_W-1]}.
  - Right: DATA <= {DATA[0], DATA[LED_W-1:1]}.
  - Wrap-around preserves the bit count.
- A bus write to DATA in the same cycle as a rotate tick wins; no rotation occurs that cycle.
- Output: led <= (phase ? DATA : 0), registered. Any optional gating is applied on top.
- No ready/waitrequest; every access completes in one cycle.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - CTRL bits[15:8] hold duty (reset 8'hFF).
  - A free-running 8-bit pwm_cnt increments every cycle.
  - led <= (phase ? DATA : 0) & {LED_W{pwm_cnt < duty}}.
  - duty = 0 means always off; duty = 255 means on 255 of 256 cycles.
- Not defined:
  - CTRL[15:8] reads 0 and ignores writes.
  - No pwm_cnt exists; led is ungated.

Test Plan:
1. Reset, then release reset_n; read addr 2 -> readdata = PERIOD_RST one cycle after the read; led = 0.
2. Write DATA = 10'h2AA, CTRL = 0 -> led = 10'h2AA on the cycle after the write; held indefinitely.
3. Write PERIOD = 3, then CTRL = 1, DATA = 10'h155 -> led alternates 10'h155 / 0 every 4 cycles; read addr 3 tracks phase.
4. PERIOD = 0, CTRL = 3'b010, DATA = 10'h200 -> led steps 10'h001, 10'h002, ... each cycle (wrap 9 -> 0). Set rotate_dir = 1 with DATA = 10'h001 -> next value 10'h200.
5. During rotation, write DATA = 10'h3FF on a tick cycle -> DATA = 10'h3FF that cycle, not rotated; a mid-count SYNC write restarts the count, next tick PERIOD+1 cycles later. Assert reset_n mid-blink -> led = 0 and cnt = 0 immediately.
6. (LED_PWM_EN) Duty = 64, DATA = 10'h001, CTRL = 0 -> led[0] high for exactly 64 of every 256 cycles. Duty = 0 -> led[0] never high.
